key_sel_counter: RTL

//   Upstream stage of the 3-8 decoder. Two raw push-buttons (up/down, active-low) are synchronised
//   and debounced. Each clean press steps a 3-bit select index with wrap-around. The index is

---
 rtl/key_sel_counter.sv | 95 +++++++++
 1 files changed

// File: rtl/key_sel_counter.sv
// Debounced up/down push-buttons stepping a 3-bit select index for the 3-8 decoder.
// Index 0 of each per-key vector is key_up, index 1 is key_down.
module key_sel_counter #(
  parameter logic [19:0] CNT_MAX  = 20'd999_999,
  parameter logic [2:0]  SEL_INIT = 3'd0
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_up,
  input  logic key_down,
  output logic in1,
  output logic in2,
  output logic in3,
  output logic sel_chg
);

  localparam int CW = $clog2(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 20'd1);

  logic [1:0]    keyRaw;
  logic [1:0]    syncA_q, syncA_d;
  logic [1:0]    syncB_q, syncB_d;
  logic [1:0]    stable_q, stable_d;
  logic [1:0]    press_q, press_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [2:0]    sel_q, sel_d;
  logic          selChg_q, selChg_d;

  assign keyRaw = {key_down, key_up};

  // press_d flags the debounced 1->0 transition so the index steps on the following edge
  always_comb begin
    syncA_d  = keyRaw;
    syncB_d  = syncA_q;
    stable_d = stable_q;
    press_d  = 2'b00;
    cnt_d    = '{default: '0};
    for (int k = 0; k < 2; k++) begin
      if (syncB_q[k] != stable_q[k]) begin
        if (cnt_q[k] == CNT_LAST) begin
          stable_d[k] = syncB_q[k];
          press_d[k]  = ~syncB_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    sel_d    = sel_q;
    selChg_d = 1'b0;
    case (press_q)
      2'b01: begin
        sel_d    = sel_q + 3'd1;
        selChg_d = 1'b1;
      end
      2'b10: begin
        sel_d    = sel_q - 3'd1;
        selChg_d = 1'b1;
      end
      default: begin
        sel_d    = sel_q;
        selChg_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      syncA_q  <= 2'b11;
      syncB_q  <= 2'b11;
      stable_q <= 2'b11;
      press_q  <= 2'b00;
      cnt_q    <= '{default: '0};
      sel_q    <= SEL_INIT;
      selChg_q <= 1'b0;
    end else begin
      syncA_q  <= syncA_d;
      syncB_q  <= syncB_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      selChg_q <= selChg_d;
    end
  end

  assign in1     = sel_q[2];
  assign in2     = sel_q[1];
  assign in3     = sel_q[0];
  assign sel_chg = selChg_q;

endmodule
